// File: rtl/shift_arbiter_if.sv
// shift_arbiter_if: request, grant and result signals between the two FP32 ALU requesters, the shared shifter and its consumer.
interface shift_arbiter_if;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [23:0] req0_mant, req1_mant;
  logic [7:0]  req0_amt, req1_amt;
  logic        out_valid, out_ready, out_tag, out_grd, out_sticky;
  logic [23:0] out_data;
  modport master (
    output req0_valid, req0_mant, req0_amt, req1_valid, req1_mant, req1_amt, out_ready,
    input  req0_ready, req1_ready, out_valid, out_tag, out_data, out_grd, out_sticky
  );
  modport slave (
    input  req0_valid, req0_mant, req0_amt, req1_valid, req1_mant, req1_amt, out_ready,
    output req0_ready, req1_ready, out_valid, out_tag, out_data, out_grd, out_sticky
  );
endinterface

// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin share of one 24-bit right shifter between two requesters, with guard/sticky and a one-entry result register.
module shift_arbiter (
  input logic clk,
  input logic rst,
  shift_arbiter_if.slave bus
);
  logic        r_last, r_valid, r_tag, r_grd, r_sticky;
  logic [23:0] r_data;
  logic        w_win, w_acc, w_big;
  logic [23:0] w_mant;
  logic [7:0]  w_amt;
  logic [4:0]  w_sel;
  logic [47:0] w_ext;
  // Shifting into a 48-bit window leaves the guard at bit 23 and the sticky field below it.
  always_comb begin
    w_win  = (bus.req0_valid & bus.req1_valid) ? ~r_last : bus.req1_valid;
    w_acc  = ~rst & (~r_valid | bus.out_ready) & (bus.req0_valid | bus.req1_valid);
    w_mant = w_win ? bus.req1_mant : bus.req0_mant;
    w_amt  = w_win ? bus.req1_amt : bus.req0_amt;
    w_big  = w_amt > 8'd24;
    w_sel  = w_big ? 5'd0 : w_amt[4:0];
    w_ext  = {w_mant, 24'd0} >> w_sel;
  end
  assign bus.req0_ready = w_acc & ~w_win;
  assign bus.req1_ready = w_acc & w_win;
  assign bus.out_valid  = r_valid;
  assign bus.out_tag    = r_tag;
  assign bus.out_data   = r_data;
  assign bus.out_grd    = r_grd;
  assign bus.out_sticky = r_sticky;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last   <= 1'b1;
      r_valid  <= 1'b0;
      r_tag    <= 1'b0;
      r_data   <= '0;
      r_grd    <= 1'b0;
      r_sticky <= 1'b0;
    end else if (w_acc) begin
      r_last   <= w_win;
      r_valid  <= 1'b1;
      r_tag    <= w_win;
      r_data   <= w_big ? 24'd0 : w_ext[47:24];
      r_grd    <= w_big ? 1'b0 : w_ext[23];
      r_sticky <= w_big ? |w_mant : |w_ext[22:0];
    end else if (bus.out_ready) begin
      r_valid  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter: scoreboard bench; an arbitration/shift model predicts readys and results, queued on acceptance and compared on delivery.
module tb_shift_arbiter;
  typedef struct packed {
    logic        tag;
    logic [23:0] data;
    logic        grd;
    logic        sticky;
  } res_t;
  logic clk = 0;
  logic rst = 1;
  int n_cmp = 0;
  int n_err = 0;
  res_t q[$];
  logic seen[$];
  logic m_last = 1;
  logic m_valid = 0;
  shift_arbiter_if bus ();
  shift_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask
  function automatic res_t model(input logic t, input logic [23:0] m, input logic [7:0] a);
    res_t r;
    int ai = a;
    r.tag = t;
    r.data = (ai >= 24) ? 24'd0 : m >> ai;
    r.grd = 1'b0;
    if (ai >= 1 && ai <= 24) r.grd = m[ai-1];
    r.sticky = 1'b0;
    for (int i = 0; i < 24; i++) if (i < ai - 1) r.sticky |= m[i];
    return r;
  endfunction
  initial forever begin
    logic sf, w, acc;
    res_t e;
    @(negedge clk);
    if (rst) begin
      q.delete();
      m_last = 1;
      m_valid = 0;
      chk("rst_r0", bus.req0_ready, 0);
      chk("rst_r1", bus.req1_ready, 0);
      chk("rst_valid", bus.out_valid, 0);
    end else begin
      chk("out_valid", bus.out_valid, m_valid);
      if (m_valid) begin
        chk("sb_nonempty", q.size() > 0, 1);
        if (q.size() > 0) begin
          e = q[0];
          chk("out_tag", bus.out_tag, e.tag);
          chk("out_data", bus.out_data, e.data);
          chk("out_grd", bus.out_grd, e.grd);
          chk("out_sticky", bus.out_sticky, e.sticky);
          if (bus.out_ready) begin
            void'(q.pop_front());
            seen.push_back(e.tag);
          end
        end
      end
      sf = !m_valid || bus.out_ready;
      w = (bus.req0_valid && bus.req1_valid) ? !m_last : bus.req1_valid;
      acc = sf && (bus.req0_valid || bus.req1_valid);
      chk("req0_ready", bus.req0_ready, acc && !w);
      chk("req1_ready", bus.req1_ready, acc && w);
      if (acc) begin
        q.push_back(w ? model(1'b1, bus.req1_mant, bus.req1_amt) : model(1'b0, bus.req0_mant, bus.req0_amt));
        m_last = w;
      end
      m_valid = acc ? 1'b1 : (bus.out_ready ? 1'b0 : m_valid);
    end
  end
  task automatic issue(input bit n, input logic [23:0] m, input logic [7:0] a);
    bit got = 0;
    if (n) begin
      bus.req1_valid = 1; bus.req1_mant = m; bus.req1_amt = a;
    end else begin
      bus.req0_valid = 1; bus.req0_mant = m; bus.req0_amt = a;
    end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = n ? bus.req1_ready : bus.req0_ready;
    end
    chk("accept", got, 1);
    @(posedge clk); #1;
    if (n) bus.req1_valid = 0; else bus.req0_valid = 0;
  endtask
  initial begin
    logic a0, a1;
    bus.req0_valid = 0; bus.req0_mant = 0; bus.req0_amt = 0;
    bus.req1_valid = 0; bus.req1_mant = 0; bus.req1_amt = 0;
    bus.out_ready = 1;
    #1;
    chk("reset_valid", bus.out_valid, 0);
    chk("reset_data", bus.out_data, 0);
    chk("reset_grd", bus.out_grd, 0);
    chk("reset_sticky", bus.out_sticky, 0);
    chk("reset_tag", bus.out_tag, 0);
    #11 rst = 0;
    @(posedge clk); #1;
    bus.req0_valid = 1; bus.req0_mant = 24'hC00001; bus.req0_amt = 8'd1;
    bus.req1_valid = 1; bus.req1_mant = 24'h800000; bus.req1_amt = 8'd24;
    @(negedge clk);
    chk("first_r0", bus.req0_ready, 1);
    chk("first_r1", bus.req1_ready, 0);
    @(posedge clk); #1;
    bus.req0_valid = 0;
    issue(1, 24'h800000, 8'd24);
    issue(1, 24'h000001, 8'd30);
    issue(1, 24'hFFFFFF, 8'd32);
    issue(0, 24'hABCDEF, 8'd0);
    issue(0, 24'hABCDEF, 8'd4);
    issue(1, 24'h123456, 8'd23);
    issue(0, 24'h800001, 8'd25);
    issue(0, 24'h400003, 8'd2);
    issue(1, 24'hFFFFFF, 8'd255);
    @(negedge clk);
    seen.delete();
    @(posedge clk); #1;
    bus.req0_valid = 1; bus.req0_mant = 24'h111111; bus.req0_amt = 8'd3;
    bus.req1_valid = 1; bus.req1_mant = 24'h222222; bus.req1_amt = 8'd5;
    repeat (8) @(posedge clk);
    #1 bus.req1_valid = 0;
    @(posedge clk); #1;
    bus.req0_valid = 0;
    repeat (2) @(negedge clk);
    chk("alt_count", seen.size(), 9);
    for (int i = 0; i < 8 && i < seen.size(); i++) chk("alt_tag", seen[i], i % 2);
    @(posedge clk); #1;
    bus.out_ready = 0;
    bus.req0_valid = 1; bus.req0_mant = 24'h5A5A5A; bus.req0_amt = 8'd7;
    @(negedge clk);
    chk("stall_accept", bus.req0_ready, 1);
    @(posedge clk); #1;
    bus.req0_valid = 0;
    bus.req1_valid = 1; bus.req1_mant = 24'h0F0F0F; bus.req1_amt = 8'd2;
    repeat (3) begin
      @(negedge clk);
      chk("stall_r1", bus.req1_ready, 0);
      chk("stall_data", bus.out_data, 24'h00B4B4);
    end
    @(posedge clk); #1;
    bus.out_ready = 1;
    @(negedge clk);
    chk("retire_r1", bus.req1_ready, 1);
    @(posedge clk); #1;
    bus.req1_valid = 0;
    bus.out_ready = 0;
    @(negedge clk);
    chk("stay_valid", bus.out_valid, 1);
    bus.req0_valid = 1; bus.req0_mant = 24'h00FF00; bus.req0_amt = 8'd9;
    bus.req1_valid = 1; bus.req1_mant = 24'hF0000F; bus.req1_amt = 8'd1;
    @(posedge clk); #3;
    rst = 1;
    #1 chk("rst_async_valid", bus.out_valid, 0);
    @(posedge clk); #3;
    rst = 0;
    bus.out_ready = 1;
    @(negedge clk);
    chk("post_rst_r0", bus.req0_ready, 1);
    chk("post_rst_r1", bus.req1_ready, 0);
    @(posedge clk);
    @(posedge clk); #1;
    bus.req1_valid = 0;
    @(posedge clk); #1;
    bus.req0_valid = 0;
    repeat (300) begin
      @(negedge clk);
      a0 = bus.req0_valid && bus.req0_ready;
      a1 = bus.req1_valid && bus.req1_ready;
      @(posedge clk); #1;
      if (!bus.req0_valid || a0) begin
        bus.req0_valid = 1'($urandom_range(0, 1));
        bus.req0_mant = 24'($urandom);
        bus.req0_amt = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 26));
      end
      if (!bus.req1_valid || a1) begin
        bus.req1_valid = 1'($urandom_range(0, 1));
        bus.req1_mant = 24'($urandom);
        bus.req1_amt = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 26));
      end
      bus.out_ready = $urandom_range(0, 3) != 0;
    end
    @(negedge clk);
    a0 = bus.req0_valid && bus.req0_ready;
    a1 = bus.req1_valid && bus.req1_ready;
    @(posedge clk); #1;
    bus.out_ready = 1;
    for (int i = 0; i < 10 && (bus.req0_valid || bus.req1_valid); i++) begin
      if (a0) bus.req0_valid = 0;
      if (a1) bus.req1_valid = 0;
      @(negedge clk);
      a0 = bus.req0_valid && bus.req0_ready;
      a1 = bus.req1_valid && bus.req1_ready;
      @(posedge clk); #1;
    end
    bus.req0_valid = 0;
    bus.req1_valid = 0;
    repeat (3) @(negedge clk);
    chk("drain", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
